// File: rtl/tile_sched_pkg.sv
// Shared constants for the tile scheduler.
// FSM encodings, depthwise kernel size, bias stride and layer-type codes.
package tile_sched_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_ADV   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int DW_KSZ     = 9;
  localparam int BIAS_BYTES = 4;

  localparam logic [1:0] LT_POINTWISE = 2'd0;
  localparam logic [1:0] LT_DEPTHWISE = 2'd1;

endpackage

// File: rtl/tile_addr_gen.sv
// Combinational DRAM address generation for one tile command.
// All products are widened to ADDR_W and wrap modulo 2^ADDR_W.
module tile_addr_gen
  import tile_sched_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CH_W   = 11,
  parameter int PL_W   = 14
) (
  input  logic              dw_i,
  input  logic [CH_W-1:0]   in_d_i,
  input  logic [CH_W-1:0]   d_base_i,
  input  logic [CH_W-1:0]   k_base_i,
  input  logic [PL_W-1:0]   plane_i,
  input  logic [PL_W-1:0]   oplane_i,
  input  logic [ADDR_W-1:0] base_ifmap_i,
  input  logic [ADDR_W-1:0] base_weight_i,
  input  logic [ADDR_W-1:0] base_bias_i,
  input  logic [ADDR_W-1:0] base_ofmap_i,
  output logic [ADDR_W-1:0] ifmap_addr_o,
  output logic [ADDR_W-1:0] weight_addr_o,
  output logic [ADDR_W-1:0] bias_addr_o,
  output logic [ADDR_W-1:0] ofmap_addr_o
);

  logic [ADDR_W-1:0] d_w;
  logic [ADDR_W-1:0] k_w;
  logic [ADDR_W-1:0] ind_w;
  logic [ADDR_W-1:0] wt_pw;
  logic [ADDR_W-1:0] wt_dw;

  assign d_w   = ADDR_W'(d_base_i);
  assign k_w   = ADDR_W'(k_base_i);
  assign ind_w = ADDR_W'(in_d_i);

  assign wt_pw = base_weight_i + k_w * ind_w + d_w;
  assign wt_dw = base_weight_i + d_w * ADDR_W'(DW_KSZ);

  assign ifmap_addr_o  = base_ifmap_i + d_w * ADDR_W'(plane_i);
  assign weight_addr_o = dw_i ? wt_dw : wt_pw;
  assign bias_addr_o   = base_bias_i + k_w * ADDR_W'(BIAS_BYTES);
  assign ofmap_addr_o  = base_ofmap_i + k_w * ADDR_W'(oplane_i);

endmodule

// File: rtl/tile_scheduler.sv
// Walks K (outer) and D (inner) channel tiles of a decoded layer,
// issuing one DMA/PE command per tile over a valid/ready handshake.
module tile_scheduler
  import tile_sched_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CH_W   = 11,
  parameter int TL_W   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic [1:0]        layer_type_i,
  input  logic [CH_W-1:0]   in_D_i,
  input  logic [CH_W-1:0]   out_K_i,
  input  logic [TL_W-1:0]   tile_D_i,
  input  logic [TL_W-1:0]   tile_K_i,
  input  logic [TL_W-1:0]   padded_R_i,
  input  logic [TL_W-1:0]   padded_C_i,
  input  logic [TL_W-1:0]   out_R_i,
  input  logic [TL_W-1:0]   out_C_i,
  input  logic [ADDR_W-1:0] base_ifmap_i,
  input  logic [ADDR_W-1:0] base_weight_i,
  input  logic [ADDR_W-1:0] base_bias_i,
  input  logic [ADDR_W-1:0] base_ofmap_i,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic [CH_W-1:0]   d_base_o,
  output logic [CH_W-1:0]   k_base_o,
  output logic [TL_W-1:0]   d_len_o,
  output logic [TL_W-1:0]   k_len_o,
  output logic              first_d_o,
  output logic              last_d_o,
  output logic [ADDR_W-1:0] ifmap_addr_o,
  output logic [ADDR_W-1:0] weight_addr_o,
  output logic [ADDR_W-1:0] bias_addr_o,
  output logic [ADDR_W-1:0] ofmap_addr_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int PL_W = 2 * TL_W;
  localparam int CW1  = CH_W + 1;

  logic [2:0]        state_q, state_d;
  logic              dw_q, dw_d;
  logic              err_q, err_d;
  logic [CH_W-1:0]   in_d_q, in_d_d;
  logic [CH_W-1:0]   out_k_q, out_k_d;
  logic [TL_W-1:0]   tile_d_q, tile_d_d;
  logic [TL_W-1:0]   tile_k_q, tile_k_d;
  logic [PL_W-1:0]   plane_q, plane_d;
  logic [PL_W-1:0]   oplane_q, oplane_d;
  logic [ADDR_W-1:0] b_if_q, b_if_d;
  logic [ADDR_W-1:0] b_wt_q, b_wt_d;
  logic [ADDR_W-1:0] b_bs_q, b_bs_d;
  logic [ADDR_W-1:0] b_of_q, b_of_d;
  logic [CH_W-1:0]   d_base_q, d_base_d;
  logic [CH_W-1:0]   k_base_q, k_base_d;

  logic [CH_W-1:0] d_rem, k_rem, k_eff;
  logic [TL_W-1:0] d_len, k_len, k_len_pw;
  logic [CW1-1:0]  d_end, k_end;
  logic            d_more, k_more, bad_cfg, issue;

  assign d_rem    = in_d_q - d_base_q;
  assign k_rem    = out_k_q - k_base_q;
  assign d_len    = (d_rem < CH_W'(tile_d_q)) ? d_rem[TL_W-1:0] : tile_d_q;
  assign k_len_pw = (k_rem < CH_W'(tile_k_q)) ? k_rem[TL_W-1:0] : tile_k_q;
  // Depthwise layers have no K loop: K follows D one-for-one.
  assign k_len    = dw_q ? d_len : k_len_pw;
  assign k_eff    = dw_q ? d_base_q : k_base_q;

  assign d_end  = CW1'(d_base_q) + CW1'(d_len);
  assign k_end  = CW1'(k_base_q) + CW1'(k_len_pw);
  assign d_more = d_end < CW1'(in_d_q);
  assign k_more = k_end < CW1'(out_k_q);

  assign bad_cfg = (tile_d_q == '0) || (in_d_q == '0) ||
                   (!dw_q && ((tile_k_q == '0) || (out_k_q == '0)));

  always_comb begin
    state_d  = state_q;
    dw_d     = dw_q;
    err_d    = err_q;
    in_d_d   = in_d_q;
    out_k_d  = out_k_q;
    tile_d_d = tile_d_q;
    tile_k_d = tile_k_q;
    plane_d  = plane_q;
    oplane_d = oplane_q;
    b_if_d   = b_if_q;
    b_wt_d   = b_wt_q;
    b_bs_d   = b_bs_q;
    b_of_d   = b_of_q;
    d_base_d = d_base_q;
    k_base_d = k_base_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          dw_d     = (layer_type_i == LT_DEPTHWISE);
          err_d    = 1'b0;
          in_d_d   = in_D_i;
          out_k_d  = out_K_i;
          tile_d_d = tile_D_i;
          tile_k_d = tile_K_i;
          plane_d  = PL_W'(padded_R_i) * PL_W'(padded_C_i);
          oplane_d = PL_W'(out_R_i) * PL_W'(out_C_i);
          b_if_d   = base_ifmap_i;
          b_wt_d   = base_weight_i;
          b_bs_d   = base_bias_i;
          b_of_d   = base_ofmap_i;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        d_base_d = '0;
        k_base_d = '0;
        if (bad_cfg) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_ready_i) state_d = S_ADV;
      end
      S_ADV: begin
        state_d = S_ISSUE;
        if (d_more) begin
          d_base_d = d_base_q + CH_W'(tile_d_q);
        end else if (!dw_q && k_more) begin
          d_base_d = '0;
          k_base_d = k_base_q + CH_W'(tile_k_q);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      dw_q     <= 1'b0;
      err_q    <= 1'b0;
      in_d_q   <= '0;
      out_k_q  <= '0;
      tile_d_q <= '0;
      tile_k_q <= '0;
      plane_q  <= '0;
      oplane_q <= '0;
      b_if_q   <= '0;
      b_wt_q   <= '0;
      b_bs_q   <= '0;
      b_of_q   <= '0;
      d_base_q <= '0;
      k_base_q <= '0;
    end else begin
      state_q  <= state_d;
      dw_q     <= dw_d;
      err_q    <= err_d;
      in_d_q   <= in_d_d;
      out_k_q  <= out_k_d;
      tile_d_q <= tile_d_d;
      tile_k_q <= tile_k_d;
      plane_q  <= plane_d;
      oplane_q <= oplane_d;
      b_if_q   <= b_if_d;
      b_wt_q   <= b_wt_d;
      b_bs_q   <= b_bs_d;
      b_of_q   <= b_of_d;
      d_base_q <= d_base_d;
      k_base_q <= k_base_d;
    end
  end

  assign issue       = (state_q == S_ISSUE);
  assign cmd_valid_o = issue;
  assign d_base_o    = d_base_q;
  assign k_base_o    = k_eff;
  assign d_len_o     = d_len;
  assign k_len_o     = k_len;
  // Flags only mean something alongside valid; keep them low otherwise.
  assign first_d_o   = issue && (dw_q || (d_base_q == '0));
  assign last_d_o    = issue && (dw_q || !d_more);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign err_o       = done_o && err_q;

  tile_addr_gen #(
    .ADDR_W (ADDR_W),
    .CH_W   (CH_W),
    .PL_W   (PL_W)
  ) u_addr (
    .dw_i          (dw_q),
    .in_d_i        (in_d_q),
    .d_base_i      (d_base_q),
    .k_base_i      (k_eff),
    .plane_i       (plane_q),
    .oplane_i      (oplane_q),
    .base_ifmap_i  (b_if_q),
    .base_weight_i (b_wt_q),
    .base_bias_i   (b_bs_q),
    .base_ofmap_i  (b_of_q),
    .ifmap_addr_o  (ifmap_addr_o),
    .weight_addr_o (weight_addr_o),
    .bias_addr_o   (bias_addr_o),
    .ofmap_addr_o  (ofmap_addr_o)
  );

endmodule

// File: tb/tb_tile_scheduler.sv
// Scoreboard bench for tile_scheduler: a loop-nest reference model
// queues expected commands; a monitor checks every valid cycle.
module tb_tile_scheduler;
  import tile_sched_pkg::*;

  typedef struct packed {
    logic [10:0] db;
    logic [10:0] kb;
    logic [6:0]  dl;
    logic [6:0]  kl;
    logic        fd;
    logic        ld;
    logic [31:0] ia;
    logic [31:0] wa;
    logic [31:0] ba;
    logic [31:0] oa;
  } cmd_t;

  logic        clk, rst_n, start_i, flush_i;
  logic [1:0]  layer_type_i;
  logic [10:0] in_D_i, out_K_i;
  logic [6:0]  tile_D_i, tile_K_i;
  logic [6:0]  padded_R_i, padded_C_i, out_R_i, out_C_i;
  logic [31:0] base_ifmap_i, base_weight_i, base_bias_i, base_ofmap_i;
  logic        cmd_valid_o, cmd_ready_i;
  logic [10:0] d_base_o, k_base_o;
  logic [6:0]  d_len_o, k_len_o;
  logic        first_d_o, last_d_o;
  logic [31:0] ifmap_addr_o, weight_addr_o, bias_addr_o, ofmap_addr_o;
  logic        busy_o, done_o, err_o;

  tile_scheduler #(.ADDR_W(32), .CH_W(11), .TL_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .flush_i(flush_i),
    .layer_type_i(layer_type_i), .in_D_i(in_D_i), .out_K_i(out_K_i),
    .tile_D_i(tile_D_i), .tile_K_i(tile_K_i),
    .padded_R_i(padded_R_i), .padded_C_i(padded_C_i),
    .out_R_i(out_R_i), .out_C_i(out_C_i),
    .base_ifmap_i(base_ifmap_i), .base_weight_i(base_weight_i),
    .base_bias_i(base_bias_i), .base_ofmap_i(base_ofmap_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .d_base_o(d_base_o), .k_base_o(k_base_o),
    .d_len_o(d_len_o), .k_len_o(k_len_o),
    .first_d_o(first_d_o), .last_d_o(last_d_o),
    .ifmap_addr_o(ifmap_addr_o), .weight_addr_o(weight_addr_o),
    .bias_addr_o(bias_addr_o), .ofmap_addr_o(ofmap_addr_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  int errors = 0;
  int checks = 0;
  cmd_t exp_q[$];
  bit   done_q[$];
  cmd_t last_hs;
  cmd_t mon_act;
  cmd_t mon_tmp;
  bit   mon_e;
  int   vcnt = 0;
  int   hs_cnt = 0;
  int   stall_cnt = 0;
  bit   bp_en = 0;
  bit   rand_rdy = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int unsigned imin(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  // Reference: plain loop nest over the tiles, addresses by arithmetic.
  function automatic void push_model(
    input logic [1:0] lt, input int unsigned ind, input int unsigned outk,
    input int unsigned td, input int unsigned tk,
    input int unsigned pr, input int unsigned pc,
    input int unsigned orr, input int unsigned oc,
    input logic [31:0] bi, input logic [31:0] bw,
    input logic [31:0] bb, input logic [31:0] bo);
    cmd_t c;
    bit dw;
    int unsigned dl, kl;
    dw = (lt == LT_DEPTHWISE);
    if (td == 0 || ind == 0 || (!dw && (tk == 0 || outk == 0))) begin
      done_q.push_back(1'b1);
      return;
    end
    if (dw) begin
      for (int unsigned d = 0; d < ind; d += td) begin
        dl = imin(td, ind - d);
        c.db = 11'(d); c.kb = 11'(d);
        c.dl = 7'(dl); c.kl = 7'(dl);
        c.fd = 1'b1; c.ld = 1'b1;
        c.ia = bi + d * pr * pc;
        c.wa = bw + d * 9;
        c.ba = bb + d * 4;
        c.oa = bo + d * orr * oc;
        exp_q.push_back(c);
      end
    end else begin
      for (int unsigned k = 0; k < outk; k += tk) begin
        for (int unsigned d = 0; d < ind; d += td) begin
          dl = imin(td, ind - d);
          kl = imin(tk, outk - k);
          c.db = 11'(d); c.kb = 11'(k);
          c.dl = 7'(dl); c.kl = 7'(kl);
          c.fd = (d == 0);
          c.ld = (d + dl >= ind);
          c.ia = bi + d * pr * pc;
          c.wa = bw + k * ind + d;
          c.ba = bb + k * 4;
          c.oa = bo + k * orr * oc;
          exp_q.push_back(c);
        end
      end
    end
    done_q.push_back(1'b0);
  endfunction

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic scramble();
    layer_type_i = 2'($urandom);
    in_D_i = 11'($urandom); out_K_i = 11'($urandom);
    tile_D_i = 7'($urandom); tile_K_i = 7'($urandom);
    padded_R_i = 7'($urandom); padded_C_i = 7'($urandom);
    out_R_i = 7'($urandom); out_C_i = 7'($urandom);
    base_ifmap_i = $urandom; base_weight_i = $urandom;
    base_bias_i = $urandom; base_ofmap_i = $urandom;
  endtask

  // Called at posedge+1; returns one cycle later with start low.
  task automatic start_layer(
    input logic [1:0] lt, input int unsigned ind, input int unsigned outk,
    input int unsigned td, input int unsigned tk,
    input int unsigned pr, input int unsigned pc,
    input int unsigned orr, input int unsigned oc,
    input logic [31:0] bi, input logic [31:0] bw,
    input logic [31:0] bb, input logic [31:0] bo);
    push_model(lt, ind, outk, td, tk, pr, pc, orr, oc, bi, bw, bb, bo);
    layer_type_i = lt;
    in_D_i = 11'(ind); out_K_i = 11'(outk);
    tile_D_i = 7'(td); tile_K_i = 7'(tk);
    padded_R_i = 7'(pr); padded_C_i = 7'(pc);
    out_R_i = 7'(orr); out_C_i = 7'(oc);
    base_ifmap_i = bi; base_weight_i = bw;
    base_bias_i = bb; base_ofmap_i = bo;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    scramble();
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d cmds left required 0", name, exp_q.size());
      exp_q.delete();
      done_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_layer();
    int unsigned ind, outk, td, tk;
    logic [1:0] lt;
    lt = ($urandom_range(0, 1) == 1) ? LT_DEPTHWISE : LT_POINTWISE;
    ind = $urandom_range(1, 64);
    outk = $urandom_range(1, 64);
    td = $urandom_range(8, 40);
    tk = $urandom_range(8, 40);
    if ($urandom_range(0, 9) == 0) td = 0;
    if ($urandom_range(0, 9) == 0) tk = 0;
    start_layer(lt, ind, outk, td, tk,
                $urandom_range(1, 127), $urandom_range(1, 127),
                $urandom_range(1, 127), $urandom_range(1, 127),
                $urandom, $urandom, $urandom, $urandom);
    wait_done("rand");
  endtask

  // Consumer: ready is always, random, or stalled 3 cycles on cmd 2.
  initial begin
    cmd_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && cmd_valid_o && cmd_ready_i) hs_cnt++;
      @(posedge clk); #1;
      if (bp_en && hs_cnt == 1 && stall_cnt < 3 && cmd_valid_o) begin
        cmd_ready_i = 1'b0;
        stall_cnt++;
      end else begin
        cmd_ready_i = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: every valid cycle must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid_o) begin
        vcnt++;
        mon_act = {d_base_o, k_base_o, d_len_o, k_len_o, first_d_o,
                   last_d_o, ifmap_addr_o, weight_addr_o, bias_addr_o,
                   ofmap_addr_o};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL cmd_unexpected: got %h required none", mon_act);
        end else begin
          if (mon_act !== exp_q[0]) begin
            errors++;
            $display("FAIL cmd: got %h required %h", mon_act, exp_q[0]);
          end
          if (cmd_ready_i) begin
            last_hs = mon_act;
            mon_tmp = exp_q.pop_front();
          end
        end
      end
      if (done_o) begin
        checks++;
        if (done_q.size() == 0 || exp_q.size() != 0) begin
          errors++;
          $display("FAIL done: got done with %0d cmds left, %0d dones expected",
                   exp_q.size(), done_q.size());
        end else begin
          mon_e = done_q.pop_front();
          if (err_o !== mon_e) begin
            errors++;
            $display("FAIL done_err: got %0b required %0b", err_o, mon_e);
          end
        end
      end
      if (err_o && !done_o) begin
        checks++;
        errors++;
        $display("FAIL err_alone: got err_o=1 required done_o=1");
      end
    end
  end

  initial begin
    int n, v0;
    rst_n = 1'b0;
    start_i = 1'b0;
    flush_i = 1'b0;
    scramble();
    #12;
    chk("reset_outs",
        {cmd_valid_o, d_base_o, k_base_o, d_len_o, k_len_o, first_d_o,
         last_d_o, ifmap_addr_o, weight_addr_o, bias_addr_o, ofmap_addr_o,
         busy_o, done_o, err_o}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: pointwise 2x2 tiles, latency and final command
    start_layer(LT_POINTWISE, 64, 64, 32, 32, 32, 32, 32, 32,
                32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000);
    chk("t1_load_valid", cmd_valid_o, 0);
    chk("t1_busy", busy_o, 1);
    @(posedge clk); #1;
    chk("t1_first_valid", cmd_valid_o, 1);
    wait_done("t1");
    chk("t1_ifmap", last_hs.ia, 32'h1000_8000);
    chk("t1_weight", last_hs.wa, 32'h2000_0820);
    chk("t1_bias", last_hs.ba, 32'h3000_0080);
    chk("t1_ofmap", last_hs.oa, 32'h4000_8000);
    chk("t1_flags", {last_hs.fd, last_hs.ld}, 2'b01);
    chk("t1_idle", busy_o, 0);

    // 2: partial D tile, K smaller than tile
    rand_rdy = 1;
    start_layer(LT_POINTWISE, 40, 16, 32, 32, 10, 10, 8, 8,
                32'h100, 32'h200, 32'h300, 32'h400);
    wait_done("t2");
    chk("t2_last_dlen", last_hs.dl, 8);

    // 3: depthwise
    start_layer(LT_DEPTHWISE, 48, 48, 32, 5, 9, 9, 7, 7,
                32'h5000, 32'h6000, 32'h7000, 32'h8000);
    wait_done("t3");
    chk("t3_weight", last_hs.wa, 32'h6120);
    chk("t3_kbase", last_hs.kb, 32);

    // 4: backpressure on the second command
    rand_rdy = 0;
    bp_en = 1;
    stall_cnt = 0;
    hs_cnt = 0;
    start_layer(LT_POINTWISE, 64, 32, 16, 16, 20, 20, 18, 18,
                $urandom, $urandom, $urandom, $urandom);
    wait_done("t4");
    chk("t4_stalls", stall_cnt, 3);
    bp_en = 0;

    // 5: illegal descriptor, then start while busy
    v0 = vcnt;
    start_layer(LT_POINTWISE, 64, 64, 0, 32, 4, 4, 4, 4, 0, 0, 0, 0);
    wait_done("t5_err");
    chk("t5_no_valid", vcnt - v0, 0);
    start_layer(LT_DEPTHWISE, 0, 16, 8, 8, 4, 4, 4, 4, 0, 0, 0, 0);
    wait_done("t5_err_dw");
    start_layer(LT_POINTWISE, 64, 32, 8, 16, 12, 12, 10, 10,
                $urandom, $urandom, $urandom, $urandom);
    repeat (3) @(posedge clk);
    #1;
    layer_type_i = LT_POINTWISE;
    in_D_i = 11'd5; out_K_i = 11'd5;
    tile_D_i = 7'd1; tile_K_i = 7'd1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_done("t5_busy_start");

    // 6: flush mid-layer, then rerun
    hs_cnt = 0;
    start_layer(LT_POINTWISE, 64, 64, 32, 32, 32, 32, 32, 32,
                32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000);
    n = 0;
    while (hs_cnt < 2 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_reached", hs_cnt >= 2, 1);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    exp_q.delete();
    done_q.delete();
    chk("t6_idle", {busy_o, cmd_valid_o, done_o}, 3'b000);
    repeat (4) @(posedge clk);
    #1;
    start_layer(LT_POINTWISE, 64, 64, 32, 32, 32, 32, 32, 32,
                32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000);
    wait_done("t6_rerun");

    // Random layers with random backpressure
    rand_rdy = 1;
    for (int i = 0; i < 25; i++) rand_layer();

    // Asynchronous reset mid-layer
    rand_rdy = 0;
    hs_cnt = 0;
    start_layer(LT_POINTWISE, 64, 64, 16, 16, 8, 8, 8, 8,
                $urandom, $urandom, $urandom, $urandom);
    n = 0;
    while (hs_cnt < 3 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_outs",
        {cmd_valid_o, d_base_o, k_base_o, d_len_o, k_len_o, first_d_o,
         last_d_o, ifmap_addr_o, weight_addr_o, bias_addr_o, ofmap_addr_o,
         busy_o, done_o, err_o}, '0);
    exp_q.delete();
    done_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rand_layer();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
